// File: rtl/matbi_watch_pkg.sv
// Shared definitions for the watch time-of-day datapath: FSM encoding,
// field widths and the fixed second/minute modulus.
package matbi_watch_pkg;

    localparam int C_SEC_MOD = 60;
    localparam int C_HOUR_W  = 5;
    localparam int C_MIN_W   = 6;
    localparam int C_SEC_W   = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LOAD = 2'd2
    } state_t;

endpackage

// File: rtl/matbi_watch_time_counter_if.sv
// Time-set load port: valid/ready handshake carrying hour/minute/second.
interface matbi_watch_time_counter_if
    import matbi_watch_pkg::*;
();

    logic                i_set_valid;
    logic                o_set_ready;
    logic [C_HOUR_W-1:0] i_set_hour;
    logic [C_MIN_W-1:0]  i_set_min;
    logic [C_SEC_W-1:0]  i_set_sec;

    modport master (
        output i_set_valid, i_set_hour, i_set_min, i_set_sec,
        input  o_set_ready
    );

    modport slave (
        input  i_set_valid, i_set_hour, i_set_min, i_set_sec,
        output o_set_ready
    );

endinterface

// File: rtl/matbi_mod_counter.sv
// Modulo-P_MOD counter field with load priority and a combinational carry
// out (o_wrap) so fields chain within the same clock edge.
module matbi_mod_counter #(
    parameter int P_MOD = 60,
    parameter int P_W   = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_inc,
    input  logic           i_load,
    input  logic [P_W-1:0] i_load_val,
    output logic [P_W-1:0] o_val,
    output logic           o_wrap
);

    localparam logic [P_W-1:0] C_LAST = P_W'(P_MOD - 1);

    logic at_last;

    assign at_last = (o_val == C_LAST);
    // Carry is suppressed during a load so the next field never advances.
    assign o_wrap  = i_inc & ~i_load & at_last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_val <= '0;
        end else if (i_load) begin
            o_val <= i_load_val;
        end else if (i_inc) begin
            o_val <= at_last ? '0 : o_val + 1'b1;
        end
    end

endmodule

// File: rtl/matbi_watch_time_counter.sv
// Time-of-day counter: advances h:m:s on the one-second tick, accepts
// range-checked loads over a valid/ready port and emits rollover pulses.
module matbi_watch_time_counter
    import matbi_watch_pkg::*;
#(
    parameter int P_HOUR_MOD = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_run_en,
    input  logic                       i_one_sec_tick,
    matbi_watch_time_counter_if.slave  set_if,
    output logic [C_HOUR_W-1:0]        o_hour,
    output logic [C_MIN_W-1:0]         o_min,
    output logic [C_SEC_W-1:0]         o_sec,
    output logic                       o_min_tick,
    output logic                       o_hour_tick,
    output logic                       o_day_tick,
    output logic                       o_set_err
);

    localparam logic [C_HOUR_W-1:0] C_HOUR_LIM = C_HOUR_W'(P_HOUR_MOD);
    localparam logic [C_MIN_W-1:0]  C_MIN_LIM  = C_MIN_W'(C_SEC_MOD);
    localparam logic [C_SEC_W-1:0]  C_SEC_LIM  = C_SEC_W'(C_SEC_MOD);

    state_t state;
    logic   set_ready;
    logic   accept;
    logic   in_range;
    logic   load_fields;
    logic   advance;
    logic   sec_wrap;
    logic   min_wrap;
    logic   hour_wrap;

    assign set_if.o_set_ready = set_ready;

    assign accept      = set_if.i_set_valid & set_ready;
    assign in_range    = (set_if.i_set_hour < C_HOUR_LIM) &
                         (set_if.i_set_min  < C_MIN_LIM)  &
                         (set_if.i_set_sec  < C_SEC_LIM);
    assign load_fields = accept & in_range;
    // An accepted load, valid or not, swallows a coincident tick.
    assign advance     = i_one_sec_tick & i_run_en & ~accept;

    matbi_mod_counter #(.P_MOD(C_SEC_MOD), .P_W(C_SEC_W)) u_sec (
        .clk        (clk),
        .reset      (reset),
        .i_inc      (advance),
        .i_load     (load_fields),
        .i_load_val (set_if.i_set_sec),
        .o_val      (o_sec),
        .o_wrap     (sec_wrap)
    );

    matbi_mod_counter #(.P_MOD(C_SEC_MOD), .P_W(C_MIN_W)) u_min (
        .clk        (clk),
        .reset      (reset),
        .i_inc      (sec_wrap),
        .i_load     (load_fields),
        .i_load_val (set_if.i_set_min),
        .o_val      (o_min),
        .o_wrap     (min_wrap)
    );

    matbi_mod_counter #(.P_MOD(P_HOUR_MOD), .P_W(C_HOUR_W)) u_hour (
        .clk        (clk),
        .reset      (reset),
        .i_inc      (min_wrap),
        .i_load     (load_fields),
        .i_load_val (set_if.i_set_hour),
        .o_val      (o_hour),
        .o_wrap     (hour_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            set_ready   <= 1'b0;
            o_min_tick  <= 1'b0;
            o_hour_tick <= 1'b0;
            o_day_tick  <= 1'b0;
            o_set_err   <= 1'b0;
        end else begin
            set_ready   <= ~accept;
            o_min_tick  <= sec_wrap;
            o_hour_tick <= min_wrap;
            o_day_tick  <= hour_wrap;
            o_set_err   <= accept & ~in_range;
            case (state)
                S_IDLE, S_RUN: begin
                    if (accept)        state <= S_LOAD;
                    else if (i_run_en) state <= S_RUN;
                    else               state <= S_IDLE;
                end
                default: state <= i_run_en ? S_RUN : S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matbi_watch_time_counter.sv
// Self-checking bench: 24h and 12h instances share stimulus and are compared
// every cycle against a seconds-of-day reference model.
module tb_matbi_watch_time_counter;
    import matbi_watch_pkg::*;

    logic clk = 1'b0;
    logic reset, run_en, tick;

    logic [4:0] h24, h12;
    logic [5:0] m24, m12, s24, s12;
    logic mt24, ht24, dt24, err24, mt12, ht12, dt12, err12;

    matbi_watch_time_counter_if if24 ();
    matbi_watch_time_counter_if if12 ();

    matbi_watch_time_counter #(.P_HOUR_MOD(24)) dut_24 (
        .clk(clk), .reset(reset), .i_run_en(run_en), .i_one_sec_tick(tick),
        .set_if(if24.slave), .o_hour(h24), .o_min(m24), .o_sec(s24),
        .o_min_tick(mt24), .o_hour_tick(ht24), .o_day_tick(dt24), .o_set_err(err24)
    );

    matbi_watch_time_counter #(.P_HOUR_MOD(12)) dut_12 (
        .clk(clk), .reset(reset), .i_run_en(run_en), .i_one_sec_tick(tick),
        .set_if(if12.slave), .o_hour(h12), .o_min(m12), .o_sec(s12),
        .o_min_tick(mt12), .o_hour_tick(ht12), .o_day_tick(dt12), .o_set_err(err12)
    );

    always #5 clk = ~clk;

    // Reference: time kept as seconds since midnight.
    typedef struct {
        int t;
        bit ready, mt, ht, dt, err;
    } model_t;

    model_t ref24, ref12;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic model_t model_next(input model_t m, input int hmod, input bit rst,
                                          input bit run, input bit tk, input bit v,
                                          input int h, input int mi, input int s);
        model_t n = m;
        bit acc;
        n.mt = 0; n.ht = 0; n.dt = 0; n.err = 0;
        if (rst) begin
            n.t = 0;
            n.ready = 0;
            return n;
        end
        acc = v && m.ready;
        n.ready = !acc;
        if (acc) begin
            if (h < hmod && mi < 60 && s < 60) n.t = h * 3600 + mi * 60 + s;
            else                               n.err = 1;
        end else if (run && tk) begin
            n.t  = (m.t + 1) % (hmod * 3600);
            n.mt = (n.t % 60) == 0;
            n.ht = (n.t % 3600) == 0;
            n.dt = n.t == 0;
        end
        return n;
    endfunction

    task automatic check_dut(input string who, input model_t m, input logic [4:0] h,
                             input logic [5:0] mi, input logic [5:0] s, input logic mt,
                             input logic ht, input logic dt, input logic err, input logic rdy);
        check({who, "_hour"}, 32'(h), 32'(m.t / 3600));
        check({who, "_min"}, 32'(mi), 32'((m.t / 60) % 60));
        check({who, "_sec"}, 32'(s), 32'(m.t % 60));
        check({who, "_min_tick"}, 32'(mt), 32'(m.mt));
        check({who, "_hour_tick"}, 32'(ht), 32'(m.ht));
        check({who, "_day_tick"}, 32'(dt), 32'(m.dt));
        check({who, "_set_err"}, 32'(err), 32'(m.err));
        check({who, "_set_ready"}, 32'(rdy), 32'(m.ready));
    endtask

    // One clock: drive inputs, advance the models at the edge, compare #1 later.
    task automatic step(input bit rst, input bit run, input bit tk, input bit v,
                        input int h, input int mi, input int s);
        reset = rst; run_en = run; tick = tk;
        if24.i_set_valid = v; if24.i_set_hour = 5'(h); if24.i_set_min = 6'(mi); if24.i_set_sec = 6'(s);
        if12.i_set_valid = v; if12.i_set_hour = 5'(h); if12.i_set_min = 6'(mi); if12.i_set_sec = 6'(s);
        @(posedge clk);
        ref24 = model_next(ref24, 24, rst, run, tk, v, h % 32, mi % 64, s % 64);
        ref12 = model_next(ref12, 12, rst, run, tk, v, h % 32, mi % 64, s % 64);
        #1;
        check_dut("d24", ref24, h24, m24, s24, mt24, ht24, dt24, err24, if24.o_set_ready);
        check_dut("d12", ref12, h12, m12, s12, mt12, ht12, dt12, err12, if12.o_set_ready);
    endtask

    int min_ticks;

    initial begin
        ref24 = '{default: 0};
        ref12 = '{default: 0};

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 3, 4, 5);
        check("rst_state", 32'(dut_24.state), 32'(S_IDLE));
        check("rst_ready", 32'(if24.o_set_ready), 32'd0);
        check("rst_sec", 32'(s24), 32'd0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("ready_after_rst", 32'(if24.o_set_ready), 32'd1);

        // 61 ticks -> 00:01:01, one minute pulse after the 60th tick
        min_ticks = 0;
        for (int i = 0; i < 61; i++) begin
            step(0, 1, 1, 0, 0, 0, 0);
            min_ticks += int'(mt24);
            if (i == 59) check("min_tick_at_60", 32'(mt24), 32'd1);
            step(0, 1, 0, 0, 0, 0, 0);
            min_ticks += int'(mt24);
        end
        check("min_tick_count", 32'(min_ticks), 32'd1);
        check("t61_min", 32'(m24), 32'd1);
        check("t61_sec", 32'(s24), 32'd1);

        // End-of-day rollover
        step(0, 1, 0, 1, 23, 59, 58);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        check("eod_sec59", 32'(s24), 32'd59);
        step(0, 1, 1, 0, 0, 0, 0);
        check("eod_hour", 32'(h24), 32'd0);
        check("eod_all_ticks", 32'({mt24, ht24, dt24}), 32'd7);

        // Out-of-range load
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 24, 10, 0);
        check("bad_err", 32'(err24), 32'd1);
        check("bad_ready_low", 32'(if24.o_set_ready), 32'd0);
        check("bad_min_kept", 32'(m24), 32'd0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("bad_err_cleared", 32'(err24), 32'd0);
        check("bad_ready_back", 32'(if24.o_set_ready), 32'd1);

        // Load beats a coincident tick; tick in LOAD applies to loaded value
        step(0, 1, 1, 1, 5, 6, 7);
        check("ld_tick_sec", 32'(s24), 32'd7);
        step(0, 1, 1, 0, 0, 0, 0);
        check("load_cycle_tick", 32'(s24), 32'd8);

        // Frozen time with run disabled, load still accepted
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0, 0);
        end
        check("frozen_sec", 32'(s24), 32'd8);
        step(0, 0, 0, 1, 1, 2, 3);
        check("idle_load", 32'({h24, m24, s24}), 32'({5'd1, 6'd2, 6'd3}));
        step(0, 0, 0, 0, 0, 0, 0);

        // 12-hour wrap vs 24-hour
        step(0, 1, 0, 1, 11, 59, 59);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        check("h12_wrap_hour", 32'(h12), 32'd0);
        check("h12_day_tick", 32'(dt12), 32'd1);
        check("h24_noon", 32'(h24), 32'd12);
        check("h24_no_day", 32'(dt24), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 19) == 0,
                 ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 23),
                 ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 59),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(55, 59) : $urandom_range(0, 63));
        end

        // Long run near a rollover boundary
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 22, 58, 30);
        for (int i = 0; i < 200; i++) step(0, 1, 1, 0, 0, 0, 0);

        // Reset in the LOAD cycle drops everything
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 3, 4, 5);
        check("pre_rst_load_state", 32'(dut_24.state), 32'(S_LOAD));
        step(1, 1, 1, 1, 6, 7, 8);
        check("rst_load_state24", 32'(dut_24.state), 32'(S_IDLE));
        check("rst_load_state12", 32'(dut_12.state), 32'(S_IDLE));
        check("rst_load_time", 32'({h24, m24, s24}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matbi_watch_time_counter.md
# matbi_watch_time_counter

Time-of-day counter that sits directly downstream of the one-second tick generator in the watch datapath. It consumes the single-cycle one-second tick and advances registered hour/minute/second fields with wrap-around at the end of the day. It also provides a valid/ready load port for setting the time, and emits minute, hour and day rollover pulses for the display and alarm stages.

## Interface
- P_HOUR_MOD, 24: hour modulus; hours count 0..P_HOUR_MOD-1. Legal values are 12 and 24.
- P_SEC_MOD, 60: second and minute modulus; fixed, held in the package.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_run_en  in  1  1 = advance on ticks; 0 = hold time (loads still accepted)
- i_one_sec_tick  in  1  single-cycle tick from the tick generator
- i_set_valid  in  1  load request
- o_set_ready  out  1  load port ready
- i_set_hour  in  5  binary hour
- i_set_min  in  6  binary minute
- i_set_sec  in  6  binary second
- o_hour  out  5  current hour, binary
- o_min  out  6  current minute, binary
- o_sec  out  6  current second, binary
- o_min_tick  out  1  pulse on second wrap 59->0
- o_hour_tick  out  1  pulse on minute wrap 59->0
- o_day_tick  out  1  pulse on hour wrap (P_HOUR_MOD-1)->0
- o_set_err  out  1  pulse when an accepted load is out of range

## Operation
- FSM states:
  - S_IDLE: i_run_en=0; time holds; ticks ignored.
  - S_RUN: i_run_en=1; each tick advances the time.
  - S_LOAD: one cycle only, entered after any load is accepted.
- Transitions:
  - IDLE<->RUN follows i_run_en.
  - A handshake (i_set_valid & o_set_ready) from IDLE or RUN -> LOAD.
  - LOAD -> RUN if i_run_en, else IDLE.
- o_set_ready = 1 in IDLE and RUN; 0 in LOAD and during reset.
- Load is accepted on the cycle valid & ready are both high.
  - If hour < P_HOUR_MOD, min < 60 and sec < 60: all three fields are written.
  - Otherwise the time is unchanged and o_set_err pulses; the FSM still enters LOAD.
- Advance on tick:
  - sec+1.
  - If sec==59: sec=0, min+1, o_min_tick.
  - If min also 59: min=0, hour+1, o_hour_tick.
  - If hour also P_HOUR_MOD-1: hour=0, o_day_tick.
- Rollover pulses are asserted together with the wrapped value. 23:59:59 + tick gives 00:00:00 with all three pulses high in the same cycle.
- Simultaneous load accept and tick: the load wins and the tick is discarded.
- A tick during the S_LOAD cycle is applied to the newly loaded value, if i_run_en=1.
- Arithmetic is plain binary per field. Compare-then-clear only; no modulo operators.

## Timing
- All outputs are registered.
- Reset values: o_hour=0, o_min=0, o_sec=0, all pulses 0, o_set_ready=0, state=S_IDLE.
- o_set_ready rises the first cycle after reset deasserts.
- Tick at edge N -> new time and pulses visible after edge N+1. Latency is 1 cycle.
- Load accepted at edge N -> fields (or o_set_err) valid after N+1. o_set_ready is low for exactly one cycle (N+1).
- Each pulse is exactly 1 cycle wide. No pulses are generated by loads.
- Reset asserted mid-operation (any state, including LOAD) clears everything on the next edge. A pending load is dropped.
- Deasserting i_run_en takes effect at the next edge; a tick coincident with i_run_en=0 is ignored.

## Structure
- Shared package matbi_watch_pkg holds:
  - the FSM state encoding (S_IDLE, S_RUN, S_LOAD);
  - C_SEC_MOD=60 and field widths C_HOUR_W=5, C_MIN_W=6, C_SEC_W=6.
- Sub-module matbi_mod_counter (parameters P_MOD, P_W; ports clk, reset, i_inc, i_load, i_load_val, o_val, o_wrap) is instantiated three times and chained via o_wrap -> i_inc. The top holds the FSM, range check and handshake.

## Test plan
- Reset, then i_run_en=1 with 61 ticks -> 00:01:01; o_min_tick high once, after the 60th tick.
- Load 23:59:58, then 2 ticks -> 23:59:59, then 00:00:00 with o_min_tick, o_hour_tick and o_day_tick high in the same cycle.
- Load hour=24, min=10, sec=0 with P_HOUR_MOD=24 -> time unchanged, o_set_err is 1 for one cycle, o_set_ready is low for one cycle.
- i_set_valid and tick in the same cycle, loading 05:06:07 -> 05:06:07 (not :08). A tick in the following LOAD cycle -> 05:06:08.
- i_run_en=0 with 10 ticks -> time frozen; a load of 01:02:03 is still accepted and shows 01:02:03.
- P_HOUR_MOD=12 at 11:59:59 plus a tick -> 00:00:00 with o_day_tick. Reset asserted in the LOAD cycle -> all outputs 0 and state IDLE.
